// File: rtl/bus_demux.sv
// Single-initiator bus demultiplexer: routes each transaction to target A, target B, or an error response.
// Optional target-wait timeout is enabled by defining BUS_DEMUX_TIMEOUT_EN.
module bus_demux #(
    parameter logic [31:0] PA_BASE        = 32'h0000_0000,
    parameter logic [31:0] PA_MASK        = 32'hF000_0000,
    parameter logic [31:0] PB_BASE        = 32'h1000_0000,
    parameter logic [31:0] PB_MASK        = 32'hF000_0000,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
    input  logic        i_clock,
    input  logic        i_reset,
    // initiator side
    input  logic        i_bus_rw,
    input  logic        i_bus_request,
    output logic        o_bus_ready,
    input  logic [31:0] i_bus_address,
    output logic [31:0] o_bus_rdata,
    input  logic [31:0] i_bus_wdata,
    output logic        o_bus_error,
    // target A
    output logic        o_pa_rw,
    output logic        o_pa_request,
    output logic [31:0] o_pa_address,
    output logic [31:0] o_pa_wdata,
    input  logic        i_pa_ready,
    input  logic [31:0] i_pa_rdata,
    // target B
    output logic        o_pb_rw,
    output logic        o_pb_request,
    output logic [31:0] o_pb_address,
    output logic [31:0] o_pb_wdata,
    input  logic        i_pb_ready,
    input  logic [31:0] i_pb_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        PA,
        PB,
        ERR,
        RELEASE
    } state_t;

    // The target command registers double as the latched copy of the transaction.
    typedef struct packed {
        logic        rw;
        logic        request;
        logic [31:0] address;
        logic [31:0] wdata;
    } tgt_cmd_t;

    state_t      state_q, state_d;
    tgt_cmd_t    pa_q, pa_d;
    tgt_cmd_t    pb_q, pb_d;
    logic        ready_q, ready_d;
    logic        error_q, error_d;
    logic [31:0] rdata_q, rdata_d;

    logic hit_a;
    logic hit_b;

    assign hit_a = (i_bus_address & PA_MASK) == PA_BASE;
    assign hit_b = (i_bus_address & PB_MASK) == PB_BASE;

`ifdef BUS_DEMUX_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_hit;

    // Fires on the waiting cycle that brings the count up to the limit.
    assign timeout_hit = ({1'b0, wait_cnt_q} + 9'd1) >= {1'b0, TIMEOUT_CYCLES};
`endif

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        pa_d    = pa_q;
        pb_d    = pb_q;
        ready_d = 1'b0;
        error_d = 1'b0;
        rdata_d = '0;
`ifdef BUS_DEMUX_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (i_bus_request) begin
                    if (hit_a) begin
                        pa_d.rw      = i_bus_rw;
                        pa_d.request = 1'b1;
                        pa_d.address = i_bus_address;
                        pa_d.wdata   = i_bus_wdata;
                        state_d      = PA;
                    end else if (hit_b) begin
                        pb_d.rw      = i_bus_rw;
                        pb_d.request = 1'b1;
                        pb_d.address = i_bus_address;
                        pb_d.wdata   = i_bus_wdata;
                        state_d      = PB;
                    end else begin
                        state_d = ERR;
                    end
`ifdef BUS_DEMUX_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
            end

            PA: begin
                if (i_pa_ready) begin
                    pa_d    = '0;
                    ready_d = 1'b1;
                    rdata_d = pa_q.rw ? '0 : i_pa_rdata;
                    state_d = RELEASE;
                end
`ifdef BUS_DEMUX_TIMEOUT_EN
                else if (timeout_hit) begin
                    pa_d    = '0;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    state_d = RELEASE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end

            PB: begin
                if (i_pb_ready) begin
                    pb_d    = '0;
                    ready_d = 1'b1;
                    rdata_d = pb_q.rw ? '0 : i_pb_rdata;
                    state_d = RELEASE;
                end
`ifdef BUS_DEMUX_TIMEOUT_EN
                else if (timeout_hit) begin
                    pb_d    = '0;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    state_d = RELEASE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end

            ERR: begin
                ready_d = 1'b1;
                error_d = 1'b1;
                state_d = RELEASE;
            end

            RELEASE: begin
                // Hold off until the initiator drops its request, so one request gives one transaction.
                if (!i_bus_request) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            pa_q    <= '0;
            pb_q    <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            ready_q <= ready_d;
            error_q <= error_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef BUS_DEMUX_TIMEOUT_EN
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign o_bus_ready  = ready_q;
    assign o_bus_error  = error_q;
    assign o_bus_rdata  = rdata_q;

    assign o_pa_rw      = pa_q.rw;
    assign o_pa_request = pa_q.request;
    assign o_pa_address = pa_q.address;
    assign o_pa_wdata   = pa_q.wdata;

    assign o_pb_rw      = pb_q.rw;
    assign o_pb_request = pb_q.request;
    assign o_pb_address = pb_q.address;
    assign o_pb_wdata   = pb_q.wdata;

endmodule

// File: tb/tb_bus_demux.sv
// Directed self-checking bench for bus_demux with simple auto-responding target models.
// Timeout behaviour is checked when BUS_DEMUX_TIMEOUT_EN is defined, indefinite wait otherwise.
module tb_bus_demux;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_bus_rw = 1'b0;
    logic        i_bus_request = 1'b0;
    logic [31:0] i_bus_address = '0;
    logic [31:0] i_bus_wdata = '0;
    logic        o_bus_ready;
    logic [31:0] o_bus_rdata;
    logic        o_bus_error;
    logic        o_pa_rw, o_pa_request, o_pb_rw, o_pb_request;
    logic [31:0] o_pa_address, o_pa_wdata, o_pb_address, o_pb_wdata;
    logic        i_pa_ready, i_pb_ready;
    logic [31:0] i_pa_rdata, i_pb_rdata;

    // target models: ready is raised after the request has been high for *_lat cycles (0 = never)
    int          pa_lat = 0, pb_lat = 0;
    logic [31:0] pa_data = '0, pb_data = '0;
    logic        pa_auto = 1'b0, pb_auto = 1'b0;
    logic        pa_junk = 1'b0, pb_junk = 1'b0;
    int          pa_cnt = 0, pb_cnt = 0;

    assign i_pa_ready = pa_auto | pa_junk;
    assign i_pb_ready = pb_auto | pb_junk;
    assign i_pa_rdata = pa_data;
    assign i_pb_rdata = pb_data;

    int n_tests = 0;
    int n_fail  = 0;

    int ready_pulses = 0, pa_hi = 0, pb_hi = 0, err_stray = 0;

    bus_demux #(
        .PA_BASE        (32'h0000_0000),
        .PA_MASK        (32'hF000_0000),
        .PB_BASE        (32'h1000_0000),
        .PB_MASK        (32'hF000_0000),
        .TIMEOUT_CYCLES (8'd4)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_bus_rw      (i_bus_rw),
        .i_bus_request (i_bus_request),
        .o_bus_ready   (o_bus_ready),
        .i_bus_address (i_bus_address),
        .o_bus_rdata   (o_bus_rdata),
        .i_bus_wdata   (i_bus_wdata),
        .o_bus_error   (o_bus_error),
        .o_pa_rw       (o_pa_rw),
        .o_pa_request  (o_pa_request),
        .o_pa_address  (o_pa_address),
        .o_pa_wdata    (o_pa_wdata),
        .i_pa_ready    (i_pa_ready),
        .i_pa_rdata    (i_pa_rdata),
        .o_pb_rw       (o_pb_rw),
        .o_pb_request  (o_pb_request),
        .o_pb_address  (o_pb_address),
        .o_pb_wdata    (o_pb_wdata),
        .i_pb_ready    (i_pb_ready),
        .i_pb_rdata    (i_pb_rdata)
    );

    initial forever #5 i_clock = ~i_clock;

    initial forever begin
        @(posedge i_clock);
        #2;
        if (o_pa_request) pa_cnt++; else pa_cnt = 0;
        if (o_pb_request) pb_cnt++; else pb_cnt = 0;
        pa_auto = (pa_lat != 0) && (pa_cnt == pa_lat);
        pb_auto = (pb_lat != 0) && (pb_cnt == pb_lat);
    end

    initial forever begin
        @(negedge i_clock);
        if (o_bus_ready) ready_pulses++;
        if (o_pa_request) pa_hi++;
        if (o_pb_request) pb_hi++;
        if (o_bus_error && !o_bus_ready) err_stray++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clock);
        #1;
    endtask

    task automatic wait_ready(input string tag, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_bus_ready && n < budget);
        if (!o_bus_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no o_bus_ready within %0d cycles", tag, budget);
        end
    endtask

    // port: 0 = unmapped, 1 = A, 2 = B; wait_cyc = cycles the target request is expected high
    task automatic run_txn(input string tag, input logic rw, input logic [31:0] addr,
                           input logic [31:0] wdata, input int port, input int wait_cyc,
                           input logic [31:0] exp_rdata, input logic exp_err);
        int p0, a0, b0, n, elapsed, exp_total;
        exp_total = (port == 0) ? 2 : wait_cyc + 1;
        p0 = ready_pulses; a0 = pa_hi; b0 = pb_hi;
        i_bus_rw = rw; i_bus_address = addr; i_bus_wdata = wdata; i_bus_request = 1'b1;
        @(posedge i_clock);
        #2;
        i_bus_rw = ~rw; i_bus_address = ~addr; i_bus_wdata = ~wdata;
        tick();
        elapsed = 1;
        check({tag, " pa_req"}, 32'(o_pa_request), 32'(port == 1));
        check({tag, " pb_req"}, 32'(o_pb_request), 32'(port == 2));
        if (port == 1) begin
            check({tag, " pa_addr"}, o_pa_address, addr);
            check({tag, " pa_wdata"}, o_pa_wdata, wdata);
            check({tag, " pa_rw"}, 32'(o_pa_rw), 32'(rw));
            check({tag, " pb_addr_idle"}, o_pb_address, 32'h0);
        end
        if (port == 2) begin
            check({tag, " pb_addr"}, o_pb_address, addr);
            check({tag, " pb_wdata"}, o_pb_wdata, wdata);
            check({tag, " pb_rw"}, 32'(o_pb_rw), 32'(rw));
            check({tag, " pa_addr_idle"}, o_pa_address, 32'h0);
        end
        if (port != 0 && wait_cyc >= 2) begin
            tick();
            elapsed++;
            check({tag, " addr_held"}, (port == 1) ? o_pa_address : o_pb_address, addr);
        end
        if (!o_bus_ready) begin
            wait_ready(tag, 64, n);
            elapsed += n;
        end
        check({tag, " latency"}, 32'(elapsed), 32'(exp_total));
        check({tag, " rdata"}, o_bus_rdata, exp_rdata);
        check({tag, " error"}, 32'(o_bus_error), 32'(exp_err));
        check({tag, " pa_req_done"}, 32'(o_pa_request), 32'h0);
        check({tag, " pb_req_done"}, 32'(o_pb_request), 32'h0);
        i_bus_request = 1'b0;
        tick();
        check({tag, " ready_drop"}, 32'(o_bus_ready), 32'h0);
        check({tag, " pulses"}, 32'(ready_pulses - p0), 32'h1);
        check({tag, " pa_hi"}, 32'(pa_hi - a0), 32'((port == 1) ? wait_cyc : 0));
        check({tag, " pb_hi"}, 32'(pb_hi - b0), 32'((port == 2) ? wait_cyc : 0));
    endtask

    logic [31:0] dec_addr [4];
    int          dec_port [4];

    initial begin
        int p0, a0, n;
        dec_addr = '{32'h0FFF_FFFC, 32'h1000_0000, 32'h1FFF_FFFF, 32'hF000_0000};
        dec_port = '{1, 2, 2, 0};

        // reset state
        tick(); tick();
        check("rst ready", 32'(o_bus_ready), 32'h0);
        check("rst error", 32'(o_bus_error), 32'h0);
        check("rst rdata", o_bus_rdata, 32'h0);
        check("rst pa_req", 32'(o_pa_request), 32'h0);
        check("rst pb_req", 32'(o_pb_request), 32'h0);
        check("rst pa_addr", o_pa_address, 32'h0);
        i_reset = 1'b1;
        tick();

        // read from A with ready three cycles in
        pa_lat = 3; pa_data = 32'h1234_5678;
        run_txn("rd_a", 1'b0, 32'h0000_0040, 32'h0, 1, 3, 32'h1234_5678, 1'b0);

        // write to B; write returns zero rdata
        pb_lat = 2; pb_data = 32'hDEAD_BEEF;
        run_txn("wr_b", 1'b1, 32'h1000_0008, 32'hCAFE_F00D, 2, 2, 32'h0, 1'b0);

        // unmapped read
        run_txn("unmap", 1'b0, 32'h2000_0000, 32'h0, 0, 0, 32'h0, 1'b1);

        // decode boundaries
        pa_lat = 1; pb_lat = 1; pa_data = 32'h0BAD_0A0A; pb_data = 32'h0BAD_0B0B;
        for (int i = 0; i < 4; i++) begin
            run_txn($sformatf("dec%0d", i), 1'b0, dec_addr[i], 32'h0, dec_port[i], 1,
                    (dec_port[i] == 1) ? 32'h0BAD_0A0A : (dec_port[i] == 2) ? 32'h0BAD_0B0B : 32'h0,
                    dec_port[i] == 0);
        end

        // request held after ready: no re-acceptance until it drops
        pa_lat = 1; pa_data = 32'hA5A5_0001;
        p0 = ready_pulses; a0 = pa_hi;
        i_bus_rw = 1'b0; i_bus_address = 32'h0000_0100; i_bus_request = 1'b1;
        wait_ready("hold", 10, n);
        check("hold latency", 32'(n), 32'h2);
        check("hold rdata", o_bus_rdata, 32'hA5A5_0001);
        repeat (4) tick();
        check("hold ready", 32'(o_bus_ready), 32'h0);
        check("hold pa_req", 32'(o_pa_request), 32'h0);
        check("hold pulses", 32'(ready_pulses - p0), 32'h1);
        check("hold pa_hi", 32'(pa_hi - a0), 32'h1);
        i_bus_request = 1'b0;
        tick();
        pa_lat = 2; pa_data = 32'h7777_1111;
        run_txn("after_rel", 1'b0, 32'h0ABC_0000, 32'h0, 1, 2, 32'h7777_1111, 1'b0);

        // stray readies ignored outside the matching state
        p0 = ready_pulses;
        pa_junk = 1'b1; pb_junk = 1'b1;
        repeat (3) tick();
        check("junk idle pulses", 32'(ready_pulses - p0), 32'h0);
        pa_junk = 1'b0;
        pa_lat = 2; pa_data = 32'h5555_AAAA; pb_data = 32'h9999_9999;
        run_txn("junk_b", 1'b0, 32'h0000_0200, 32'h0, 1, 2, 32'h5555_AAAA, 1'b0);
        pb_junk = 1'b0;

        // ready arriving on the last allowed waiting cycle still wins
        pa_lat = 4; pa_data = 32'h4444_0004;
        run_txn("late_rdy", 1'b0, 32'h0000_0300, 32'h0, 1, 4, 32'h4444_0004, 1'b0);

        // target A never ready
        pa_lat = 0;
`ifdef BUS_DEMUX_TIMEOUT_EN
        run_txn("timeout", 1'b0, 32'h0000_0400, 32'h0, 1, 4, 32'h0, 1'b1);
`else
        p0 = ready_pulses;
        i_bus_rw = 1'b0; i_bus_address = 32'h0000_0400; i_bus_request = 1'b1;
        repeat (20) tick();
        check("stuck pulses", 32'(ready_pulses - p0), 32'h0);
        check("stuck pa_req", 32'(o_pa_request), 32'h1);
        i_reset = 1'b0;
        i_bus_request = 1'b0;
        tick();
        check("stuck rst pa_req", 32'(o_pa_request), 32'h0);
        i_reset = 1'b1;
        tick();
`endif

        // reset mid-transaction on B
        pb_lat = 0;
        i_bus_rw = 1'b1; i_bus_address = 32'h1000_0010; i_bus_wdata = 32'h1111_2222; i_bus_request = 1'b1;
        tick();
        check("mid pb_req", 32'(o_pb_request), 32'h1);
        p0 = ready_pulses;
        #2;
        i_reset = 1'b0;
        #1;
        check("arst pb_req", 32'(o_pb_request), 32'h0);
        check("arst pb_rw", 32'(o_pb_rw), 32'h0);
        check("arst pb_addr", o_pb_address, 32'h0);
        check("arst pb_wdata", o_pb_wdata, 32'h0);
        check("arst ready", 32'(o_bus_ready), 32'h0);
        i_bus_request = 1'b0;
        tick(); tick();
        check("arst pulses", 32'(ready_pulses - p0), 32'h0);

        // first edge after reset release accepts
        pa_lat = 1; pa_data = 32'h0F0F_F0F0;
        i_reset = 1'b1;
        run_txn("post_rst", 1'b0, 32'h0000_0500, 32'h0, 1, 1, 32'h0F0F_F0F0, 1'b0);

        check("err_without_ready", 32'(err_stray), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
